// File: rtl/log_mem_ctrl_pkg.sv
// Shared constants and state type for the data-log capture controller.
// The default widths match the register file's view of the log memory.
package log_mem_ctrl_pkg;

    localparam int unsigned NB_ADDR_MEM_DEF = 15;
    localparam int unsigned NB_DATA_DEF     = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

endpackage

// File: rtl/log_mem_ctrl_if.sv
// Register-file / datapath-tap bundle for the log memory controller.
// The master side drives the commands and samples; the slave side is the controller.
interface log_mem_ctrl_if #(
    parameter int unsigned NB_ADDR_MEM = 15,
    parameter int unsigned NB_DATA     = 32
) ();

    logic                   i_run_log;
    logic                   i_read_log;
    logic [NB_ADDR_MEM-1:0] i_addr_log;
    logic                   i_log_valid;
    logic [NB_DATA-1:0]     i_log_data;
    logic [NB_DATA-1:0]     o_data_log;
    logic                   o_mem_full;
    logic                   o_busy;
    logic [NB_ADDR_MEM:0]   o_wr_count;

    modport master (
        output i_run_log, i_read_log, i_addr_log, i_log_valid, i_log_data,
        input  o_data_log, o_mem_full, o_busy, o_wr_count
    );

    modport slave (
        input  i_run_log, i_read_log, i_addr_log, i_log_valid, i_log_data,
        output o_data_log, o_mem_full, o_busy, o_wr_count
    );

endinterface

// File: rtl/log_mem_ctrl_log_ram.sv
// Simple dual-port log RAM: one write port, one registered read-first read port.
// Written so synthesis maps it onto block RAM with a resettable output register.
module log_ram #(
    parameter int unsigned NB_ADDR_MEM = 15,
    parameter int unsigned NB_DATA     = 32
) (
    input  logic                   clk,
    input  logic                   rst_i,
    input  logic                   wr_en_i,
    input  logic [NB_ADDR_MEM-1:0] wr_addr_i,
    input  logic [NB_DATA-1:0]     wr_data_i,
    input  logic                   rd_en_i,
    input  logic [NB_ADDR_MEM-1:0] rd_addr_i,
    output logic [NB_DATA-1:0]     rd_data_o
);

    logic [NB_DATA-1:0] mem [2**NB_ADDR_MEM];
    logic [NB_DATA-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Non-blocking write above makes a same-address read return the old word.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/log_mem_ctrl.sv
// Capture/readback controller: fills the log RAM on a run_log rising edge until
// full, and serves register-file reads independently through the second port.
module log_mem_ctrl
    import log_mem_ctrl_pkg::*;
#(
    parameter int unsigned NB_ADDR_MEM = NB_ADDR_MEM_DEF,
    parameter int unsigned NB_DATA     = NB_DATA_DEF
) (
    input  logic           clk,
    input  logic           i_rst,
    log_mem_ctrl_if.slave  bus
);

    state_e                 state_q, state_d;
    logic [NB_ADDR_MEM-1:0] wptr_q, wptr_d;
    logic [NB_ADDR_MEM:0]   cnt_q, cnt_d;
    logic                   prev_run_q;
    logic                   run_start;
    logic                   wr_en;

    assign run_start = bus.i_run_log & ~prev_run_q;
    assign wr_en     = (state_q == ST_CAPTURE) & bus.i_log_valid;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            wptr_q     <= '0;
            cnt_q      <= '0;
            prev_run_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            cnt_q      <= cnt_d;
            prev_run_q <= bus.i_run_log;
        end
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        if (wr_en) begin
            wptr_d = wptr_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
        end
        case (state_q)
            ST_IDLE:    if (run_start) state_d = ST_CAPTURE;
            ST_CAPTURE: if (wr_en && (wptr_q == '1)) state_d = ST_FULL;
            ST_FULL:    if (run_start) state_d = ST_CAPTURE;
            default:    state_d = ST_IDLE;
        endcase
        // A restart wins over a coincident write: the word still lands, pointers restart.
        if (run_start) begin
            state_d = ST_CAPTURE;
            wptr_d  = '0;
            cnt_d   = '0;
        end
    end

    assign bus.o_busy     = (state_q == ST_CAPTURE);
    assign bus.o_mem_full = (state_q == ST_FULL);
    assign bus.o_wr_count = cnt_q;

    log_ram #(
        .NB_ADDR_MEM (NB_ADDR_MEM),
        .NB_DATA     (NB_DATA)
    ) u_log_ram (
        .clk       (clk),
        .rst_i     (i_rst),
        .wr_en_i   (wr_en),
        .wr_addr_i (wptr_q),
        .wr_data_i (bus.i_log_data),
        .rd_en_i   (bus.i_read_log),
        .rd_addr_i (bus.i_addr_log),
        .rd_data_o (bus.o_data_log)
    );

endmodule
